rr_req_arbiter: RTL

- Round-robin arbiter that shares one encoded-output resource among N requesters.
- Issues a registered one-hot grant plus its binary index, in the same encoding as the team's one-hot-to-binary encoder.
- Holds a grant until the owner drops its request.
- Sits between the requesting agents and the shared encoder/datapath; the datapath consumes grant_idx directly.

---
 rtl/rr_req_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rr_req_arbiter.sv
// ---------------------------------------------------------------------------
// rr_req_arbiter
//   Round-robin arbiter sharing one resource among N requesters. The winner
//   receives a registered one-hot grant plus its binary index, and keeps the
//   grant until it drops its request. Every handover costs one dead cycle.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When defined, an owner that has held the grant for MAX_HOLD cycles is
//     forcibly released as if it had dropped its request.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst_n      in   1   synchronous active-low reset
//   req        in   N   request vector, bit k = requester k wants the resource
//   grant      out  N   registered one-hot grant, zero when no owner
//   grant_idx  out  IW  binary index of the owner, zero when no owner
//   grant_vld  out  1   high while any grant bit is high
//   busy_cnt   out  8   saturating count of cycles the owner has held grant
//
// Handshake: a requester holds req high for as long as it wants the resource.
// A grant appears one clock after req is sampled in IDLE and is withdrawn one
// clock after the owner's req is sampled low (or the hold limit is reached).
// ---------------------------------------------------------------------------
module rr_req_arbiter #(
    parameter int N        = 4,
    parameter int IW       = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld,
    output logic [7:0]    busy_cnt
);

`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // state_q is the FSM state; a checker can bind to it directly.
    state_t         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IW-1:0]  idx_q,   idx_d;
    logic [7:0]     cnt_q,   cnt_d;
    logic [IW-1:0]  last_q,  last_d;

    logic           found;
    logic [IW-1:0]  pick;
    logic [IW:0]    sum;
    logic [IW-1:0]  cand;
    logic           release_now;

    // Search from last+1 upward with wrap; the first set request wins.
    // sum is one bit wider so last+i (at most 2N-1) never overflows.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last_q} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // The timeout term is constant-false unless the feature is built in.
    assign release_now = !req[idx_q] ||
                         (TIMEOUT_ON && (cnt_q == 8'(MAX_HOLD)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = OWN;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    idx_d         = pick;
                    cnt_d         = 8'd1;
                end
            end
            OWN: begin
                if (release_now) begin
                    // Releasing owner becomes lowest priority next round.
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    cnt_d   = 8'd0;
                    last_d  = idx_q;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            cnt_q   <= 8'd0;
            last_q  <= IW'(N-1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign grant_vld = |grant_q;
    assign busy_cnt  = cnt_q;

endmodule
